// File: rtl/freq_div_pkg.sv
// -----------------------------------------------------------------------------
// freq_div_pkg
// Shared constants and helpers for the programmable clock divider.
//   FD_W       : default width of the divisor/high-time fields and the counter
//   clamp_t    : clamped (divisor, high-time) pair plus an error flag
//   clamp_cfg  : legalises a requested (D, H) pair
// -----------------------------------------------------------------------------
package freq_div_pkg;

    localparam int unsigned FD_W = 8;

    // Fields are 32 bits wide so that one helper serves any divider width.
    // Callers zero-extend their W-bit inputs and truncate the results. This is
    // safe because a clamped value never exceeds max(D, 2).
    typedef struct packed {
        logic        err;
        logic [31:0] div;
        logic [31:0] high;
    } clamp_t;

    // The divisor must be at least 2. The high time must satisfy 1..D-1.
    // An illegal high time falls back to D/2, computed from the divisor after
    // the divisor itself has been clamped.
    function automatic clamp_t clamp_cfg(input logic [31:0] d, input logic [31:0] h);
        clamp_t r;
        r.err  = 1'b0;
        r.div  = d;
        r.high = h;
        if (d < 32'd2) begin
            r.div = 32'd2;
            r.err = 1'b1;
        end
        if ((h == 32'd0) || (h >= r.div)) begin
            r.high = r.div >> 1;
            r.err  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_div_shadow.sv
// -----------------------------------------------------------------------------
// freq_div_shadow
// Configuration path of the divider. The block captures a load request into a
// clamped shadow and holds it pending. At a period boundary it copies the
// shadow into the active registers, then pulses load_ack on the next cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : 1-cycle capture request for i_div_val / i_high_val
//   i_div_val      : requested divisor
//   i_high_val     : requested high time
//   i_boundary     : current edge is a period boundary (wrap, or en low)
//   o_div_act      : active divisor
//   o_high_act     : active high time
//   o_load_ack     : 1-cycle pulse, the cycle after the new values went live
//   o_cfg_err      : sticky flag, set when a request had to be clamped
// -----------------------------------------------------------------------------
module freq_div_shadow
    import freq_div_pkg::*;
#(
    parameter int unsigned W            = FD_W,
    parameter int unsigned DEFAULT_DIV  = 4,
    parameter int unsigned DEFAULT_HIGH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_div_val,
    input  logic [W-1:0] i_high_val,
    input  logic         i_boundary,
    output logic [W-1:0] o_div_act,
    output logic [W-1:0] o_high_act,
    output logic         o_load_ack,
    output logic         o_cfg_err
);

    logic [W-1:0] r_sh_div, r_sh_high, r_div_act, r_high_act;
    logic         r_pending, r_load_ack, r_cfg_err;

    clamp_t       w_cl;
    logic [W-1:0] w_cl_div, w_cl_high;
    logic         w_apply;

    assign w_cl      = clamp_cfg(32'(i_div_val), 32'(i_high_val));
    assign w_cl_div  = W'(w_cl.div);
    assign w_cl_high = W'(w_cl.high);

    // A load that arrives exactly on a boundary goes live at that same edge,
    // so the apply condition also includes the load request itself.
    assign w_apply   = i_boundary && (r_pending || i_load);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_div   <= W'(DEFAULT_DIV);
            r_sh_high  <= W'(DEFAULT_HIGH);
            r_div_act  <= W'(DEFAULT_DIV);
            r_high_act <= W'(DEFAULT_HIGH);
            r_pending  <= 1'b0;
            r_load_ack <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_load_ack <= w_apply;
            if (i_load) begin
                // The most recent request overwrites any earlier pending one.
                r_sh_div  <= w_cl_div;
                r_sh_high <= w_cl_high;
                if (w_cl.err) r_cfg_err <= 1'b1;
            end
            if (w_apply) begin
                r_div_act  <= i_load ? w_cl_div  : r_sh_div;
                r_high_act <= i_load ? w_cl_high : r_sh_high;
                r_pending  <= 1'b0;
            end else if (i_load) begin
                r_pending  <= 1'b1;
            end
        end
    end

    assign o_div_act  = r_div_act;
    assign o_high_act = r_high_act;
    assign o_load_ack = r_load_ack;
    assign o_cfg_err  = r_cfg_err;

endmodule

// File: rtl/freq_divider_prog.sv
// -----------------------------------------------------------------------------
// freq_divider_prog
// Runtime-programmable integer clock divider. A period lasts div_act cycles,
// and clk_out is high for the first high_act cycles of each period. A new
// configuration takes effect only at a period boundary, so clk_out never
// produces a runt pulse.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   en       : 1 = divide, 0 = hold counter at 0 with outputs low
//   div_val  : requested divisor (W bits)
//   high_val : requested high time (W bits)
//   load     : 1-cycle request to capture div_val / high_val
//   load_ack : 1-cycle pulse once the requested values are active
//   clk_out  : divided clock, registered
//   tick     : 1-cycle pulse on the last cycle of each period, registered
//   cfg_err  : sticky clamp indicator, cleared only by rst
// -----------------------------------------------------------------------------
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int unsigned W            = FD_W,
    parameter int unsigned DEFAULT_DIV  = 4,
    parameter int unsigned DEFAULT_HIGH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic [W-1:0] high_val,
    input  logic         load,
    output logic         load_ack,
    output logic         clk_out,
    output logic         tick,
    output logic         cfg_err
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;
    logic         r_clk_out, r_tick;

    logic [W-1:0] w_div_act, w_high_act;
    logic         w_wrap, w_boundary;

    assign w_wrap     = (r_cnt == (w_div_act - ONE));
    // While the divider is disabled, every edge counts as a boundary. A
    // pending load therefore takes effect at the next edge.
    assign w_boundary = !en || w_wrap;

    freq_div_shadow #(
        .W            (W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_shadow (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (load),
        .i_div_val  (div_val),
        .i_high_val (high_val),
        .i_boundary (w_boundary),
        .o_div_act  (w_div_act),
        .o_high_act (w_high_act),
        .o_load_ack (load_ack),
        .o_cfg_err  (cfg_err)
    );

    // The outputs decode the counter before its update, which makes them
    // lag r_cnt by one cycle. When a new configuration is applied, the
    // counter restarts at 0 on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_boundary ? '0 : (r_cnt + ONE);
            r_clk_out <= en && (r_cnt < w_high_act);
            r_tick    <= en && w_wrap;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule
